pe_act_broadcast_ctrl: RTL and testbench
========================================

// Module: pe_act_broadcast_ctrl
// PURPOSE
//  Sequences one PE's local input activations onto the activation broadcast network, one layer at a time.
//  On start it scans the activation register file half selected by the direction bit and skips zero values.
//  Each nonzero entry becomes one packet {global_idx, value}; the scan ends with an all-zero end-of-layer
//  packet, which the consuming compute FSMs treat as the layer terminator.
//  Sits between the PE computation FSM (start/dir) and the PE router injection port (valid/ready).
// PARAMETERS
//  NUM_PE_W  2   log2(number of PEs); global_idx = {local_addr, PE_IDX}
//  ACT_NO_W  8   width of local activation count/address
//  ADDR_W    10  packet index width; must equal ACT_NO_W+NUM_PE_W
//  DATA_W    16  activation value width
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                async active-low reset
//  PE_IDX          in   NUM_PE_W         static PE index
//  bcast_start     in   1                1-cycle pulse: begin layer broadcast
//  act_regfile_dir in   1                regfile half to read; latched at bcast_start
//  in_act_no       in   ACT_NO_W         local activations this layer; latched at bcast_start
//  rf_rd_en        out  1                regfile read strobe
//  rf_rd_dir       out  1                regfile half for the read
//  rf_rd_addr      out  ACT_NO_W         local read address
//  rf_rd_data      in   DATA_W           read data, valid the cycle after rf_rd_en
//  pkt_valid       out  1                packet valid to router
//  pkt_ready       in   1                router accepts packet
//  pkt_data        out  ADDR_W+DATA_W    {idx, value}; all-zero = end of layer
//  busy            out  1                high from the cycle after start until the EOL handshake
//  bcast_done      out  1                1-cycle pulse the cycle after the EOL handshake
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; addr counter, in-flight flag and FIFO cleared. Mid-operation reset
//   aborts the layer with no EOL; the next bcast_start begins cleanly.
//  FSM states: IDLE, SCAN, EOL, DONE.
//   IDLE -> SCAN on bcast_start; latch dir and in_act_no; addr=0.
//   SCAN: issue rf_rd_en when addr<in_act_no_q and (fifo_count+inflight)<2; addr++ on issue.
//   SCAN -> EOL when addr==in_act_no_q, inflight==0 and the last returned data has been written.
//   EOL: push all-zero packet into the FIFO once it has space, then wait for the FIFO to drain.
//   EOL -> DONE on the EOL packet handshake.
//   DONE: pulse bcast_done for one cycle -> IDLE.
//  Read return (cycle after rf_rd_en):
//   if rf_rd_data!=0, write {addr_q, PE_IDX, rf_rd_data} to the FIFO; if ==0, drop it.
//   Credit scheme: the FIFO never overflows.
//  Latency: start at edge E0 -> rf_rd_en high in cycle E0+1 -> earliest pkt_valid in cycle E0+3.
//   Sustained rate is 1 packet/cycle with ready held high.
//  Handshake: transfer when pkt_valid&&pkt_ready. While valid&&!ready, pkt_data holds stable and valid stays high.
//  Packet order = ascending local addr, then EOL.
//  Boundaries:
//   in_act_no==0, or all values zero: no reads produce packets; the EOL packet is the only packet.
//   in_act_no==2^ACT_NO_W-1: addr compare must not wrap (use ACT_NO_W+1-bit counter).
//   bcast_start while busy: ignored, no effect on the latched values.
//   Simultaneous FIFO push and pop at count 2 is legal; count stays 2.
// STRUCTURE
//  Shared package/header: PE_DATA_WIDTH, PE_QUEUE_WIDTH, EOL_PKT constant (all zeros), FSM state encodings.
//  Sub-module pe_pkt_skid_fifo: 2-entry FWFT FIFO (push, pop, full, count, dout), registered outputs.
//  Top level holds the FSM, address/credit counters and the packet formatter.
// TESTING
//  NUM_PE_W=2, PE_IDX=3, in_act_no=4, data [5,0,0,7], ready=1
//   -> packets (idx3,5), (idx15,7), EOL 0; bcast_done once.
//  in_act_no=0 -> no rf_rd_en; single EOL packet; busy high for exactly the EOL path.
//  8 nonzero values, pkt_ready toggling 1,0,0,1,...
//   -> all 8 packets in order then EOL; pkt_data stable across stalls; no loss or duplication.
//  ready=1, 16 nonzero values -> pkt_valid continuously high for 16 cycles (1/cycle throughput).
//  Second bcast_start mid-scan -> ignored; output identical to a single start.
//   Then new start with dir=1 -> reads use rf_rd_dir=1.
//  rst_n low mid-scan -> all outputs 0 next cycle, no EOL; a fresh start afterward yields the full correct stream.

Source files
------------

// File: rtl/pe_act_broadcast_ctrl_pkg.sv
// Shared widths, packet payload, end-of-layer constant and FSM encodings
// for the PE activation broadcast controller.
package pe_act_broadcast_ctrl_pkg;

    localparam int unsigned NUM_PE_W       = 2;
    localparam int unsigned ACT_NO_W       = 8;
    localparam int unsigned ADDR_W         = ACT_NO_W + NUM_PE_W;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned PE_DATA_WIDTH  = DATA_W;
    localparam int unsigned PE_QUEUE_WIDTH = ADDR_W + DATA_W;
    localparam int unsigned CNT_W          = ACT_NO_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] value;
    } pkt_t;

    localparam pkt_t EOL_PKT = '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EOL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Global index places the local address above the PE index.
    function automatic pkt_t make_pkt(input logic [ACT_NO_W-1:0] addr,
                                      input logic [NUM_PE_W-1:0] pe,
                                      input logic [DATA_W-1:0]   value);
        pkt_t p;
        p.idx   = {addr, pe};
        p.value = value;
        return p;
    endfunction

endpackage

// File: rtl/pe_act_broadcast_ctrl_if.sv
// Packet injection bus between the broadcast controller and the PE router.
interface pe_act_broadcast_ctrl_if;
    import pe_act_broadcast_ctrl_pkg::*;

    logic pkt_valid;
    logic pkt_ready;
    pkt_t pkt_data;

    modport master (output pkt_valid, output pkt_data, input pkt_ready);
    modport slave  (input pkt_valid, input pkt_data, output pkt_ready);

endinterface

// File: rtl/pe_act_broadcast_ctrl_skid_fifo.sv
// Two-entry first-word-fall-through packet FIFO; head entry and flags are registers.
module pe_pkt_skid_fifo
    import pe_act_broadcast_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  pkt_t       din_i,
    output logic       full_o,
    output logic [1:0] count_o,
    output logic       valid_o,
    output pkt_t       dout_o
);

    pkt_t       head_q, head_d;
    pkt_t       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       valid_q, full_q;
    logic       pop_c, push_c;

    assign pop_c  = pop_i && (count_q != 2'd0);
    assign push_c = push_i && ((count_q != 2'd2) || pop_c);

    // Head always holds the oldest entry; pops shift the tail forward.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push_c) begin
                    head_d  = din_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_d = din_i;
                end else if (push_c) begin
                    tail_d  = din_i;
                    count_d = 2'd2;
                end else if (pop_c) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop_c) begin
                    head_d = tail_q;
                    if (push_c) begin
                        tail_d = din_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
            full_q  <= (count_d == 2'd2);
        end
    end

    assign full_o  = full_q;
    assign count_o = count_q;
    assign valid_o = valid_q;
    assign dout_o  = head_q;

endmodule

// File: rtl/pe_act_broadcast_ctrl.sv
// Scans one regfile half per layer, forwards nonzero activations as {global_idx, value}
// packets to the router and closes the layer with an all-zero end-of-layer packet.
module pe_act_broadcast_ctrl
    import pe_act_broadcast_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PE_W-1:0]   PE_IDX,
    input  logic                  bcast_start,
    input  logic                  act_regfile_dir,
    input  logic [ACT_NO_W-1:0]   in_act_no,
    output logic                  rf_rd_en,
    output logic                  rf_rd_dir,
    output logic [ACT_NO_W-1:0]   rf_rd_addr,
    input  logic [DATA_W-1:0]     rf_rd_data,
    pe_act_broadcast_ctrl_if.master pkt_if,
    output logic                  busy,
    output logic                  bcast_done
);

    logic [1:0]          state_q, state_d;
    logic                dir_q, dir_d;
    logic [ACT_NO_W-1:0] act_no_q, act_no_d;
    logic [CNT_W-1:0]    addr_q, addr_d;
    logic [ACT_NO_W-1:0] ret_addr_q, ret_addr_d;
    logic                ret_q, ret_d;
    logic                eol_pushed_q, eol_pushed_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                scan_left_c, credit_ok_c, issue_c;
    logic                pop_c, push_c, data_push_c, eol_push_c, eol_hs_c;
    pkt_t                push_pkt_c;
    logic [1:0]          fifo_count;
    logic                fifo_full, fifo_valid;
    pkt_t                fifo_dout;

    // A read is allowed only if its data is guaranteed a FIFO slot, counting the pop this cycle.
    assign scan_left_c = addr_q < {1'b0, act_no_q};
    assign pop_c       = fifo_valid && pkt_if.pkt_ready;
    assign credit_ok_c = (3'(fifo_count) + 3'(ret_q)) < (3'd2 + 3'(pop_c));
    assign issue_c     = (state_q == ST_SCAN) && scan_left_c && credit_ok_c;

    assign data_push_c = ret_q && (rf_rd_data != '0);
    assign eol_push_c  = (state_q == ST_EOL) && !eol_pushed_q && (!fifo_full || pop_c);
    assign push_c      = data_push_c || eol_push_c;
    assign push_pkt_c  = eol_push_c ? EOL_PKT : make_pkt(ret_addr_q, PE_IDX, rf_rd_data);

    // Nothing is pushed after EOL, so a pop of the last entry is the EOL handshake.
    assign eol_hs_c = (state_q == ST_EOL) && eol_pushed_q && pop_c && (fifo_count == 2'd1);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        act_no_d     = act_no_q;
        addr_d       = addr_q;
        ret_addr_d   = ret_addr_q;
        ret_d        = issue_c;
        eol_pushed_d = eol_pushed_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bcast_start) begin
                    state_d      = ST_SCAN;
                    dir_d        = act_regfile_dir;
                    act_no_d     = in_act_no;
                    addr_d       = '0;
                    eol_pushed_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_SCAN: begin
                if (issue_c) begin
                    addr_d     = addr_q + CNT_W'(1);
                    ret_addr_d = addr_q[ACT_NO_W-1:0];
                end
                if (!scan_left_c && !ret_q) begin
                    state_d = ST_EOL;
                end
            end
            ST_EOL: begin
                if (eol_push_c) begin
                    eol_pushed_d = 1'b1;
                end
                if (eol_hs_c) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            act_no_q     <= '0;
            addr_q       <= '0;
            ret_addr_q   <= '0;
            ret_q        <= 1'b0;
            eol_pushed_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            act_no_q     <= act_no_d;
            addr_q       <= addr_d;
            ret_addr_q   <= ret_addr_d;
            ret_q        <= ret_d;
            eol_pushed_q <= eol_pushed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    pe_pkt_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   (push_pkt_c),
        .full_o  (fifo_full),
        .count_o (fifo_count),
        .valid_o (fifo_valid),
        .dout_o  (fifo_dout)
    );

    assign rf_rd_en         = issue_c;
    assign rf_rd_dir        = dir_q;
    assign rf_rd_addr       = addr_q[ACT_NO_W-1:0];
    assign pkt_if.pkt_valid = fifo_valid;
    assign pkt_if.pkt_data  = fifo_dout;
    assign busy             = busy_q;
    assign bcast_done       = done_q;

endmodule

// File: tb/tb_pe_act_broadcast_ctrl.sv
// Self-checking bench: regfile model plus a filter-the-array packet reference per layer.
module tb_pe_act_broadcast_ctrl;
    import pe_act_broadcast_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pe_idx = 2'd3;
    logic        bcast_start;
    logic        act_regfile_dir;
    logic [7:0]  in_act_no;
    logic        rf_rd_en;
    logic        rf_rd_dir;
    logic [7:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        busy;
    logic        bcast_done;

    pe_act_broadcast_ctrl_if pkt_if();

    pe_act_broadcast_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PE_IDX          (pe_idx),
        .bcast_start     (bcast_start),
        .act_regfile_dir (act_regfile_dir),
        .in_act_no       (in_act_no),
        .rf_rd_en        (rf_rd_en),
        .rf_rd_dir       (rf_rd_dir),
        .rf_rd_addr      (rf_rd_addr),
        .rf_rd_data      (rf_rd_data),
        .pkt_if          (pkt_if),
        .busy            (busy),
        .bcast_done      (bcast_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rf_mem [2][256];
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];

    // Regfile: data one cycle after the strobe; junk otherwise to expose stray captures.
    always @(posedge clk) rf_rd_data <= rf_rd_en ? rf_mem[rf_rd_dir][rf_rd_addr] : 16'hBEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 random with ~25% zeros, 1 all nonzero, 2 all zero; beyond n always nonzero.
    task automatic fill(input bit dir, input int n, input int kind);
        for (int a = 0; a < 256; a++) begin
            if (a < n && kind == 2)
                rf_mem[dir][a] = 16'h0;
            else if (a < n && kind == 0 && $urandom_range(0, 3) == 0)
                rf_mem[dir][a] = 16'h0;
            else
                rf_mem[dir][a] = 16'($urandom_range(1, 65535));
        end
    endtask

    task automatic run_layer(input string tag, input int n, input bit dir, input int mode,
                             input int restart_k, input int exp_run, input int exp_first);
        int rd_cnt = 0, rd_bad = 0, dir_bad = 0, busy_bad = 0, stall_bad = 0;
        int done_cnt = 0, first_k = 0, run = 0, max_run = 0;
        int budget;
        bit eol_seen = 0, finished = 0, prev_stall = 0, r;
        logic [25:0] prev_data = '0;
        logic [25:0] g;

        exp_q.delete();
        got_q.delete();
        for (int a = 0; a < n; a++)
            if (rf_mem[dir][a] != 16'h0) exp_q.push_back({8'(a), pe_idx, rf_mem[dir][a]});
        exp_q.push_back(26'h0);

        budget          = 6 * n + 80;
        in_act_no       = 8'(n);
        act_regfile_dir = dir;
        bcast_start     = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= budget && !finished; k++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((k - 1) % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pkt_if.pkt_ready = r;
            if (k == restart_k) begin
                bcast_start     = 1'b1;
                act_regfile_dir = ~dir;
                in_act_no       = 8'(n + 37);
            end else begin
                bcast_start = 1'b0;
            end
            @(negedge clk);
            if (rf_rd_en === 1'b1) begin
                if (rf_rd_dir !== dir) dir_bad++;
                if (rf_rd_addr !== 8'(rd_cnt)) rd_bad++;
                rd_cnt++;
            end
            if (prev_stall && (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data !== prev_data)) stall_bad++;
            if (pkt_if.pkt_valid === 1'b1 && first_k == 0) first_k = k;
            if (pkt_if.pkt_valid === 1'b1 && pkt_if.pkt_data != 26'h0) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (!eol_seen && busy !== 1'b1) busy_bad++;
            if (bcast_done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) busy_bad++;
            end else if (eol_seen && done_cnt > 0) begin
                finished = 1'b1;
            end
            if (pkt_if.pkt_valid === 1'b1 && pkt_if.pkt_ready === 1'b1) begin
                got_q.push_back(pkt_if.pkt_data);
                if (pkt_if.pkt_data == 26'h0) eol_seen = 1'b1;
            end
            prev_stall = (pkt_if.pkt_valid === 1'b1 && pkt_if.pkt_ready !== 1'b1);
            prev_data  = pkt_if.pkt_data;
            @(posedge clk); #1;
        end
        bcast_start = 1'b0;

        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_reads"}, rd_cnt, n);
        check({tag, "_read_order"}, rd_bad, 0);
        check({tag, "_read_dir"}, dir_bad, 0);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_stall_hold"}, stall_bad, 0);
        check({tag, "_pkt_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            check($sformatf("%s_pkt%0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
        if (exp_run > 0)   check({tag, "_valid_run"}, max_run, exp_run);
        if (exp_first > 0) check({tag, "_first_valid_cycle"}, first_k, exp_first);
    endtask

    initial begin
        rst_n            = 1'b0;
        bcast_start      = 1'b0;
        act_regfile_dir  = 1'b0;
        in_act_no        = 8'd0;
        pkt_if.pkt_ready = 1'b0;
        #12;
        check("rst_rd_en", 32'(rf_rd_en), 0);
        check("rst_valid", 32'(pkt_if.pkt_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(bcast_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed example: [5,0,0,7] from PE 3 -> idx 3 and idx 15, then EOL.
        fill(0, 4, 1);
        rf_mem[0][0] = 16'd5;
        rf_mem[0][1] = 16'd0;
        rf_mem[0][2] = 16'd0;
        rf_mem[0][3] = 16'd7;
        run_layer("basic", 4, 1'b0, 0, 0, 0, 3);
        check("basic_idx3", 32'((got_q.size() > 0) ? got_q[0] : 26'h3FFFFFF), 32'({10'd3, 16'd5}));
        check("basic_idx15", 32'((got_q.size() > 1) ? got_q[1] : 26'h3FFFFFF), 32'({10'd15, 16'd7}));

        run_layer("empty", 0, 1'b0, 0, 0, 0, 0);

        fill(0, 8, 1);
        run_layer("stall", 8, 1'b0, 1, 0, 0, 0);

        fill(0, 16, 1);
        run_layer("tput", 16, 1'b0, 0, 0, 16, 0);

        fill(0, 12, 0);
        run_layer("restart", 12, 1'b0, 2, 3, 0, 0);

        fill(0, 256, 1);
        fill(1, 10, 0);
        run_layer("dir1", 10, 1'b1, 2, 0, 0, 0);

        fill(0, 6, 2);
        run_layer("allzero", 6, 1'b0, 0, 0, 0, 0);

        fill(1, 255, 0);
        run_layer("max", 255, 1'b1, 2, 0, 0, 0);

        // Abort a layer with reset while reads are outstanding.
        fill(1, 20, 1);
        in_act_no        = 8'd20;
        act_regfile_dir  = 1'b1;
        pkt_if.pkt_ready = 1'b0;
        bcast_start      = 1'b1;
        @(posedge clk); #1;
        bcast_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_rd_en", 32'(rf_rd_en), 0);
        check("abort_rd_dir", 32'(rf_rd_dir), 0);
        check("abort_rd_addr", 32'(rf_rd_addr), 0);
        check("abort_valid", 32'(pkt_if.pkt_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(bcast_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill(0, 20, 0);
        run_layer("after_abort", 20, 1'b0, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
